// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : cpu_pkg
// Brief    : State encoding, decoder field values and select constants for
//            the simple-RISC controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT   = 3'd0,
    DECODE = 3'd1,
    WR_IMM = 3'd2,
    GET_A  = 3'd3,
    GET_B  = 3'd4,
    ALU    = 3'd5,
    WR_REG = 3'd6,
    HALT   = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  localparam logic [2:0] NSEL_RN    = 3'b001;
  localparam logic [2:0] NSEL_RD    = 3'b010;
  localparam logic [2:0] NSEL_RM    = 3'b100;

  localparam logic [3:0] VSEL_C      = 4'b0001;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;

endpackage

`default_nettype wire

// File: rtl/cpu_controller_if.sv
//------------------------------------------------------------------------------
// Module   : cpu_controller_if
// Brief    : Decoder-to-controller inputs and controller-to-datapath strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_controller_if #(
  parameter int VSEL_W = 4
);
  logic              s;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        nsel;
  logic [VSEL_W-1:0] vsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              asel;
  logic              bsel;
  logic              write;
  logic              w;
  logic              illegal;

  // master = the controller, slave = decoder/datapath side
  modport master (
    input  s, opcode, op,
    output nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, w, illegal
  );

  modport slave (
    output s, opcode, op,
    input  nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, w, illegal
  );
endinterface

`default_nettype wire

// File: rtl/cpu_controller.sv
//------------------------------------------------------------------------------
// Module   : cpu_controller
// Brief    : Moore FSM sequencing the simple-RISC datapath one instruction at
//            a time.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_controller
  import cpu_pkg::*;
#(
  parameter int VSEL_W       = 4,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  cpu_controller_if.master bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_illegal;
  logic              r_asel_zero;
  logic              r_is_cmp;

  state_t            w_dec_target;
  logic              w_legal;
  logic              w_dec_asel_zero;
  logic              w_dec_is_cmp;

  logic [2:0]        w_nsel;
  logic [VSEL_W-1:0] w_vsel;
  logic              w_loada, w_loadb, w_loadc, w_loads;
  logic              w_asel, w_bsel, w_write, w_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WAIT;
    else          r_state <= w_next;
  end

  // Instruction class is latched in DECODE so ALU-cycle outputs stay a pure
  // function of registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal   <= 1'b0;
      r_asel_zero <= 1'b0;
      r_is_cmp    <= 1'b0;
    end else begin
      if (r_state == WAIT && bus.s) begin
        r_illegal <= 1'b0;
      end else if (r_state == DECODE) begin
        r_illegal   <= ~w_legal;
        r_asel_zero <= w_dec_asel_zero;
        r_is_cmp    <= w_dec_is_cmp;
      end
    end
  end

  always_comb begin
    w_dec_target    = WAIT;
    w_legal         = 1'b1;
    w_dec_asel_zero = 1'b0;
    w_dec_is_cmp    = 1'b0;
    case ({bus.opcode, bus.op})
      {OPC_MOV, OP_MOV_IMM}: w_dec_target = WR_IMM;
      {OPC_MOV, OP_MOV_REG},
      {OPC_ALU, OP_MVN}: begin
        w_dec_target    = GET_B;
        w_dec_asel_zero = 1'b1;
      end
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_AND}: w_dec_target = GET_A;
      {OPC_ALU, OP_CMP}: begin
        w_dec_target = GET_A;
        w_dec_is_cmp = 1'b1;
      end
      default: begin
        w_legal      = 1'b0;
        w_dec_target = ILLEGAL_TRAP ? HALT : WAIT;
      end
    endcase
  end

  always_comb begin
    w_next = WAIT;
    case (r_state)
      WAIT:    w_next = bus.s ? DECODE : WAIT;
      DECODE:  w_next = w_dec_target;
      WR_IMM:  w_next = WAIT;
      GET_A:   w_next = GET_B;
      GET_B:   w_next = ALU;
      ALU:     w_next = r_is_cmp ? WAIT : WR_REG;
      WR_REG:  w_next = WAIT;
      HALT:    w_next = HALT;
      default: w_next = WAIT;
    endcase
  end

  always_comb begin
    w_nsel  = 3'b000;
    w_vsel  = '0;
    w_loada = 1'b0;
    w_loadb = 1'b0;
    w_loadc = 1'b0;
    w_loads = 1'b0;
    w_asel  = 1'b0;
    w_bsel  = 1'b0;
    w_write = 1'b0;
    w_w     = 1'b0;
    case (r_state)
      WAIT:   w_w = 1'b1;
      WR_IMM: begin
        w_nsel  = NSEL_RN;
        w_vsel  = VSEL_SXIMM8;
        w_write = 1'b1;
      end
      GET_A: begin
        w_nsel  = NSEL_RN;
        w_loada = 1'b1;
      end
      GET_B: begin
        w_nsel  = NSEL_RM;
        w_loadb = 1'b1;
      end
      ALU: begin
        w_asel  = r_asel_zero;
        w_loads = r_is_cmp;
        w_loadc = ~r_is_cmp;
      end
      WR_REG: begin
        w_nsel  = NSEL_RD;
        w_vsel  = VSEL_C;
        w_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.nsel    = w_nsel;
  assign bus.vsel    = w_vsel;
  assign bus.loada   = w_loada;
  assign bus.loadb   = w_loadb;
  assign bus.loadc   = w_loadc;
  assign bus.loads   = w_loads;
  assign bus.asel    = w_asel;
  assign bus.bsel    = w_bsel;
  assign bus.write   = w_write;
  assign bus.w       = w_w;
  assign bus.illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_cpu_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_cpu_controller
// Brief    : Self-checking bench for cpu_controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_controller;

  logic clk;
  logic reset_n;

  cpu_controller_if #(.VSEL_W(4)) bus0 ();
  cpu_controller_if #(.VSEL_W(4)) bus1 ();

  cpu_controller #(.VSEL_W(4), .ILLEGAL_TRAP(1'b0)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  cpu_controller #(.VSEL_W(4), .ILLEGAL_TRAP(1'b1)) u_dut_trap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [2:0] opc;
    logic [1:0] op;
    int         busy;
    int         na, nb, nc, ns, nw;
    logic       asel;
    logic [3:0] vsel_wr;
    logic [2:0] nsel_wr;
    logic [2:0] nsel_a;
    logic [2:0] nsel_b;
    logic       illegal;
  } vec_t;

  vec_t vecs [8];

  int total = 0;
  int bad   = 0;

  int         obs_busy, obs_a, obs_b, obs_c, obs_s, obs_w;
  logic       obs_asel, obs_bsel, obs_onehot_bad, obs_timeout;
  logic [3:0] obs_vsel_wr;
  logic [2:0] obs_nsel_wr, obs_nsel_a, obs_nsel_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Start one instruction with a single-cycle s pulse and record what the
  // controller does until w returns high.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input bit pulse_mid);
    bus0.opcode = opc;
    bus0.op     = o;
    bus0.s      = 1'b1;
    tick();
    bus0.s = 1'b0;
    obs_busy = 0; obs_a = 0; obs_b = 0; obs_c = 0; obs_s = 0; obs_w = 0;
    obs_asel = 1'b0; obs_bsel = 1'b0; obs_onehot_bad = 1'b0;
    obs_vsel_wr = 4'b0; obs_nsel_wr = 3'b0; obs_nsel_a = 3'b0; obs_nsel_b = 3'b0;
    for (int k = 0; k < 20 && bus0.w == 1'b0; k++) begin
      obs_busy++;
      obs_a += int'(bus0.loada);
      obs_b += int'(bus0.loadb);
      obs_c += int'(bus0.loadc);
      obs_s += int'(bus0.loads);
      obs_w += int'(bus0.write);
      obs_asel |= bus0.asel;
      obs_bsel |= bus0.bsel;
      if ($countones({bus0.loada, bus0.loadb, bus0.loadc, bus0.loads, bus0.write}) > 1)
        obs_onehot_bad = 1'b1;
      if (bus0.loada) obs_nsel_a = bus0.nsel;
      if (bus0.loadb) obs_nsel_b = bus0.nsel;
      if (bus0.write) begin
        obs_vsel_wr = bus0.vsel;
        obs_nsel_wr = bus0.nsel;
      end
      bus0.s = (pulse_mid && k == 1);
      tick();
    end
    bus0.s = 1'b0;
    obs_timeout = (bus0.w == 1'b0);
  endtask

  task automatic chk_row(input vec_t v);
    chk({v.nm, " timeout"}, {31'b0, obs_timeout}, 32'd0);
    chk({v.nm, " busy"},    obs_busy, v.busy);
    chk({v.nm, " loada"},   obs_a, v.na);
    chk({v.nm, " loadb"},   obs_b, v.nb);
    chk({v.nm, " loadc"},   obs_c, v.nc);
    chk({v.nm, " loads"},   obs_s, v.ns);
    chk({v.nm, " write"},   obs_w, v.nw);
    chk({v.nm, " asel"},    {31'b0, obs_asel}, {31'b0, v.asel});
    chk({v.nm, " bsel"},    {31'b0, obs_bsel}, 32'd0);
    chk({v.nm, " onehot"},  {31'b0, obs_onehot_bad}, 32'd0);
    chk({v.nm, " vsel_wr"}, {28'b0, obs_vsel_wr}, {28'b0, v.vsel_wr});
    chk({v.nm, " nsel_wr"}, {29'b0, obs_nsel_wr}, {29'b0, v.nsel_wr});
    chk({v.nm, " nsel_a"},  {29'b0, obs_nsel_a}, {29'b0, v.nsel_a});
    chk({v.nm, " nsel_b"},  {29'b0, obs_nsel_b}, {29'b0, v.nsel_b});
    chk({v.nm, " illegal"}, {31'b0, bus0.illegal}, {31'b0, v.illegal});
  endtask

  function automatic logic [11:0] outs0();
    return {bus0.nsel, bus0.vsel, bus0.loada, bus0.loadb, bus0.loadc,
            bus0.loads, bus0.asel, bus0.bsel, bus0.write};
  endfunction

  function automatic logic [11:0] outs1();
    return {bus1.nsel, bus1.vsel, bus1.loada, bus1.loadb, bus1.loadc,
            bus1.loads, bus1.asel, bus1.bsel, bus1.write};
  endfunction

  logic [7:0] wpat;

  initial begin
    //          name    opc     op     busy a  b  c  s  w  asel vsel_wr  nsel_wr nsel_a  nsel_b  ill
    vecs[0] = '{"ILL0", 3'b111, 2'b00, 1,   0, 0, 0, 0, 0, 1'b0, 4'b0000, 3'b000, 3'b000, 3'b000, 1'b1};
    vecs[1] = '{"MOVI", 3'b110, 2'b10, 2,   0, 0, 0, 0, 1, 1'b0, 4'b0100, 3'b001, 3'b000, 3'b000, 1'b0};
    vecs[2] = '{"ADD",  3'b101, 2'b00, 5,   1, 1, 1, 0, 1, 1'b0, 4'b0001, 3'b010, 3'b001, 3'b100, 1'b0};
    vecs[3] = '{"CMP",  3'b101, 2'b01, 4,   1, 1, 0, 1, 0, 1'b0, 4'b0000, 3'b000, 3'b001, 3'b100, 1'b0};
    vecs[4] = '{"AND",  3'b101, 2'b10, 5,   1, 1, 1, 0, 1, 1'b0, 4'b0001, 3'b010, 3'b001, 3'b100, 1'b0};
    vecs[5] = '{"MVN",  3'b101, 2'b11, 4,   0, 1, 1, 0, 1, 1'b1, 4'b0001, 3'b010, 3'b000, 3'b100, 1'b0};
    vecs[6] = '{"MOVR", 3'b110, 2'b00, 4,   0, 1, 1, 0, 1, 1'b1, 4'b0001, 3'b010, 3'b000, 3'b100, 1'b0};
    vecs[7] = '{"ILL1", 3'b110, 2'b01, 1,   0, 0, 0, 0, 0, 1'b0, 4'b0000, 3'b000, 3'b000, 3'b000, 1'b1};

    reset_n     = 1'b0;
    bus0.s      = 1'b0; bus0.opcode = 3'b000; bus0.op = 2'b00;
    bus1.s      = 1'b0; bus1.opcode = 3'b000; bus1.op = 2'b00;
    tick();
    tick();
    chk("reset w",       {31'b0, bus0.w}, 32'd1);
    chk("reset outs",    {20'b0, outs0()}, 32'd0);
    chk("reset illegal", {31'b0, bus0.illegal}, 32'd0);
    #2 reset_n = 1'b1;
    tick();
    chk("idle w", {31'b0, bus0.w}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_instr(vecs[i].opc, vecs[i].op, 1'b0);
      chk_row(vecs[i]);
    end

    // s pulse during busy cycles must not extend or restart the ADD
    run_instr(3'b101, 2'b00, 1'b1);
    chk_row(vecs[2]);
    tick();
    chk("pulse ignored w", {31'b0, bus0.w}, 32'd1);

    // async reset in the middle of GET_B
    bus0.opcode = 3'b101; bus0.op = 2'b00; bus0.s = 1'b1;
    tick();
    bus0.s = 1'b0;
    tick();
    tick();
    chk("getb loadb", {31'b0, bus0.loadb}, 32'd1);
    chk("getb nsel",  {29'b0, bus0.nsel}, 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("rst mid w",     {31'b0, bus0.w}, 32'd1);
    chk("rst mid loadb", {31'b0, bus0.loadb}, 32'd0);
    chk("rst mid nsel",  {29'b0, bus0.nsel}, 32'd0);
    #1 reset_n = 1'b1;
    tick();
    run_instr(3'b101, 2'b00, 1'b0);
    chk_row(vecs[2]);

    // s held high: MOV imm then CMP back to back
    bus0.opcode = 3'b110; bus0.op = 2'b10; bus0.s = 1'b1;
    tick();
    wpat = 8'b0;
    obs_s = 0;
    for (int k = 0; k < 8; k++) begin
      wpat[k] = bus0.w;
      obs_s += int'(bus0.loads);
      if (bus0.w) begin
        bus0.opcode = 3'b101; bus0.op = 2'b01;
      end
      if (k == 7) bus0.s = 1'b0;
      tick();
    end
    chk("b2b w pattern", {24'b0, wpat}, 32'h84);
    chk("b2b cmp loads", obs_s, 1);
    chk("b2b end w", {31'b0, bus0.w}, 32'd1);
    tick();
    chk("b2b stays idle", {31'b0, bus0.w}, 32'd1);

    // trapping variant: unsupported op parks in HALT until reset
    bus1.opcode = 3'b111; bus1.op = 2'b00; bus1.s = 1'b1;
    tick();
    bus1.s = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("trap w",       {31'b0, bus1.w}, 32'd0);
    chk("trap illegal", {31'b0, bus1.illegal}, 32'd1);
    chk("trap outs",    {20'b0, outs1()}, 32'd0);
    bus1.opcode = 3'b110; bus1.op = 2'b10; bus1.s = 1'b1;
    tick();
    tick();
    chk("trap holds w",    {31'b0, bus1.w}, 32'd0);
    chk("trap holds outs", {20'b0, outs1()}, 32'd0);
    bus1.s = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("trap reset w",       {31'b0, bus1.w}, 32'd1);
    chk("trap reset illegal", {31'b0, bus1.illegal}, 32'd0);
    #1 reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
